wb_timer_slave: RTL and testbench
=================================

// Module: wb_timer_slave
// PURPOSE
//  Wishbone B4 pipelined responder: 16-bit timer/compare peripheral on one I/O slot of the
//  CPU interconnect. It answers with STALL/ACK and supplies read data, i.e. the responder
//  end of the bus. Provides a prescaled up-counter, compare-match flag and interrupt.
// PARAMETERS
//  PRESCALE     16  clock cycles per counter tick (>=1; 1 = tick every cycle)
//  WAIT_STATES  0   stall cycles inserted before each access is accepted (0..15)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst_n    in   1   asynchronous active-low reset
//  cyc_i    in   1   Wishbone CYC
//  stb_i    in   1   Wishbone STB
//  we_i     in   1   Wishbone WE (1 = write)
//  adr_i    in   2   register word select (interconnect address low bits)
//  dat_i    in   16  write data
//  dat_o    out  16  read data, valid only while ack_o=1
//  ack_o    out  1   access acknowledge
//  stall_o  out  1   pipeline stall
//  irq_o    out  1   compare-match interrupt (level)
// BEHAVIOUR
//  Reset: ack_o=0, dat_o=0, irq_o=0, stall_o=0; CTRL=0, COUNT=0, COMPARE=FFFFh, MATCH=0, FSM=IDLE.
//  Registers (adr_i):
//   0 CTRL    [0]EN [1]AUTO_RELOAD [2]IRQ_EN, other bits read 0
//   1 COUNT   read current value; write loads counter and clears prescaler
//   2 COMPARE read/write
//   3 STATUS  [0]MATCH; write 1 to bit0 clears, write 0 no effect
//  Handshake: valid = cyc_i & stb_i. Access accepted in a cycle with valid & ~stall_o.
//   ack_o=1 exactly one cycle after acceptance, for one cycle; dat_o registered with it.
//   dat_o=0 on write acks and whenever ack_o=0.
//   Writes take effect at the acceptance edge; reads return pre-write state of that edge.
//  FSM (WAIT_STATES>0): IDLE -valid-> WAIT (stall_o=1, wcnt=WAIT_STATES-1);
//   WAIT: stall_o=1 while wcnt!=0, decrement; at wcnt=0 stall_o=0, accept, -> IDLE.
//   cyc_i=0 in WAIT -> IDLE, no ack, no register effect. stb_i dropping in WAIT likewise.
//   Each subsequent access pays WAIT_STATES stall cycles again.
//  WAIT_STATES=0: stall_o constantly 0; back-to-back strobes accepted every cycle,
//   one ack per strobe in order, ack stream = strobe stream delayed 1 cycle.
//  cyc_i=0 in the ack cycle: ack_o still pulses (bus ignores it); no state rollback.
//  Counter: while EN, prescaler counts 0..PRESCALE-1; tick at PRESCALE-1.
//   On tick with COUNT==COMPARE: MATCH<=1; AUTO_RELOAD ? COUNT<=0 : (COUNT holds, EN<=0).
//   On tick otherwise: COUNT<=COUNT+1, 16-bit wrap FFFFh->0000h, no MATCH on wrap.
//   EN=0: counter and prescaler hold.
//  Simultaneous events: COUNT write beats tick; CTRL write beats one-shot EN clear;
//   MATCH set beats STATUS clear in the same cycle; COMPARE write used from next cycle.
//  Reset asserted mid-access: all state to reset values immediately; pending ack dropped.
// CONFIGURATION
//  WB_TIMER_IRQ_EN defined: irq_o registered = MATCH & CTRL.IRQ_EN (1 cycle after MATCH set,
//   drops 1 cycle after clear). Undefined: irq_o tied 0, CTRL[2] not stored, reads 0.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> ack_o=0, stall_o=0, reads CTRL=0000h, COMPARE=FFFFh.
//  2 WAIT_STATES=0: 4 back-to-back writes COMPARE=0005h,COUNT=0003h then 2 reads
//    -> 4+2 acks on consecutive cycles, reads return 0005h, 0003h.
//  3 WAIT_STATES=3: single read -> stall_o=1 for 3 cycles, accept, ack 1 cycle later;
//    drop cyc_i during stall -> no ack, bus idle next cycle.
//  4 PRESCALE=1, COMPARE=0004h, CTRL=0003h -> MATCH after 5 ticks, COUNT wraps 0 and
//    repeats; CTRL=0001h -> COUNT stays 0004h, EN reads 0.
//  5 STATUS write 0001h on the same cycle as match tick -> MATCH remains 1;
//    COUNT write 0010h on a tick -> reads 0010h.
//  6 WB_TIMER_IRQ_EN on: IRQ_EN=1, match -> irq_o=1 next cycle, clear STATUS -> irq_o=0;
//    macro off -> irq_o stays 0, CTRL reads 0003h after writing 0007h.

Source files
------------

// File: rtl/wb_timer_slave.sv
// Wishbone B4 pipelined responder exposing a prescaled 16-bit timer with compare match.
// Optional interrupt output and CTRL.IRQ_EN storage enabled by defining WB_TIMER_IRQ_EN.
module wb_timer_slave #(
  parameter int PRESCALE    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        irq_o
);

  localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PTOP = PW'(PRESCALE - 1);
  localparam logic [3:0]     WTOP = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state, state_nxt;
  logic [3:0]     wcnt, wcnt_nxt;
  logic           valid, accept;
  logic           en, ar, ctrl_ie, match;
  logic [15:0]    count, compare, rdata;
  logic [PW-1:0]  presc;
  logic           wr, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic           tick, fire, hit;

  assign valid = cyc_i & stb_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // A dropped strobe in WAIT abandons the access; the next one pays full wait states.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    stall_o   = 1'b0;
    accept    = 1'b0;
    if (WAIT_STATES == 0) begin
      accept = valid;
    end else begin
      case (state)
        S_IDLE: if (valid) begin
          stall_o   = 1'b1;
          state_nxt = S_WAIT;
          wcnt_nxt  = WTOP;
        end
        S_WAIT: begin
          if (!valid) begin
            state_nxt = S_IDLE;
          end else if (wcnt != 4'd0) begin
            stall_o  = 1'b1;
            wcnt_nxt = wcnt - 4'd1;
          end else begin
            accept    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign wr        = accept & we_i;
  assign wr_ctrl   = wr & (adr_i == 2'd0);
  assign wr_count  = wr & (adr_i == 2'd1);
  assign wr_cmp    = wr & (adr_i == 2'd2);
  assign wr_status = wr & (adr_i == 2'd3);

  assign tick = en & (presc == PTOP);
  assign fire = tick & ~wr_count;  // a COUNT write swallows a coincident tick
  assign hit  = (count == compare);

  always_comb begin
    rdata = '0;
    case (adr_i)
      2'd0: rdata = {13'd0, ctrl_ie, ar, en};
      2'd1: rdata = count;
      2'd2: rdata = compare;
      2'd3: rdata = {15'd0, match};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o   <= 1'b0;
      dat_o   <= '0;
      en      <= 1'b0;
      ar      <= 1'b0;
      count   <= '0;
      compare <= 16'hFFFF;
      match   <= 1'b0;
      presc   <= '0;
    end else begin
      ack_o <= accept;
      dat_o <= (accept && !we_i) ? rdata : '0;

      if (wr_count) begin
        count <= dat_i;
        presc <= '0;
      end else if (en) begin
        if (tick) begin
          presc <= '0;
          if (hit) begin
            if (ar) count <= '0;
          end else begin
            count <= count + 16'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end

      if (wr_ctrl) begin
        en <= dat_i[0];
        ar <= dat_i[1];
      end else if (fire && hit && !ar) begin
        en <= 1'b0;
      end

      if (wr_cmp) compare <= dat_i;

      if (fire && hit)                match <= 1'b1;
      else if (wr_status && dat_i[0]) match <= 1'b0;
    end
  end

`ifdef WB_TIMER_IRQ_EN
  logic ie, irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= dat_i[2];
      irq_q <= match & ie;
    end
  end
  assign ctrl_ie = ie;
  assign irq_o   = irq_q;
`else
  assign ctrl_ie = 1'b0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_timer_slave.sv
// Scoreboarded bench: dut0 (PRESCALE=1, no wait states) and dut1 (WAIT_STATES=3).
module tb_wb_timer_slave;
  localparam logic [1:0] CTRL = 2'd0, COUNT = 2'd1, COMPARE = 2'd2, STATUS = 2'd3;
`ifdef WB_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cyc0 = 0, stb0 = 0, we0 = 0, cyc1 = 0, stb1 = 0, we1 = 0;
  logic [1:0] adr0 = 0, adr1 = 0;
  logic [15:0] di0 = 0, di1 = 0, dat0, dat1, e0, e1;
  logic ack0, ack1, stall0, stall1, irq0, irq1;

  int vectors = 0, miscompares = 0, ack_cnt0 = 0, n, base;
  logic [15:0] q0[$], q1[$];

  wb_timer_slave #(.PRESCALE(1), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0), .adr_i(adr0),
    .dat_i(di0), .dat_o(dat0), .ack_o(ack0), .stall_o(stall0), .irq_o(irq0));

  wb_timer_slave #(.PRESCALE(16), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc1), .stb_i(stb1), .we_i(we1), .adr_i(adr1),
    .dat_i(di1), .dat_o(dat1), .ack_o(ack1), .stall_o(stall1), .irq_o(irq1));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitors: every ack pops one expected read value (0 for writes).
  always @(negedge clk) if (rst_n) begin
    if (ack0) begin
      ack_cnt0++;
      if (q0.size() == 0) chk("dut0 unexpected ack", 16'd1, 16'd0);
      else begin e0 = q0.pop_front(); chk("dut0 ack data", dat0, e0); end
    end else chk("dut0 dat idle", dat0, 16'h0);
    if (ack1) begin
      if (q1.size() == 0) chk("dut1 unexpected ack", 16'd1, 16'd0);
      else begin e1 = q1.pop_front(); chk("dut1 ack data", dat1, e1); end
    end else chk("dut1 dat idle", dat1, 16'h0);
  end

  task automatic wr0(input logic [1:0] a, input logic [15:0] d);
    cyc0 = 1; stb0 = 1; we0 = 1; adr0 = a; di0 = d;
    q0.push_back(16'h0);
    @(posedge clk); #1;
    cyc0 = 0; stb0 = 0; we0 = 0;
  endtask

  task automatic rd0(input logic [1:0] a, input logic [15:0] exp);
    cyc0 = 1; stb0 = 1; we0 = 0; adr0 = a;
    q0.push_back(exp);
    @(posedge clk); #1;
    cyc0 = 0; stb0 = 0;
  endtask

  task automatic idle0(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Holds the request until stall_o drops; reports the number of stalled cycles.
  task automatic acc1(input logic w, input logic [1:0] a, input logic [15:0] d,
                      input logic [15:0] exp, output int stalls);
    cyc1 = 1; stb1 = 1; we1 = w; adr1 = a; di1 = d;
    q1.push_back(w ? 16'h0 : exp);
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!stall1) break;
      stalls++;
      if (stalls > 20) begin chk("dut1 stall timeout", 16'd1, 16'd0); break; end
    end
    @(posedge clk); #1;
    cyc1 = 0; stb1 = 0; we1 = 0;
  endtask

  initial begin
    #12;
    chk("reset ack0", {15'd0, ack0}, 16'd0);
    chk("reset stall0", {15'd0, stall0}, 16'd0);
    chk("reset irq0", {15'd0, irq0}, 16'd0);
    chk("reset dat0", dat0, 16'd0);
    chk("reset ack1", {15'd0, ack1}, 16'd0);
    chk("reset stall1", {15'd0, stall1}, 16'd0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    rd0(CTRL, 16'h0000); rd0(COMPARE, 16'hFFFF); rd0(STATUS, 16'h0000); rd0(COUNT, 16'h0000);
    idle0(1);

    // back-to-back burst: six acks on six consecutive cycles
    base = ack_cnt0;
    wr0(CTRL, 16'h0); wr0(STATUS, 16'h1); wr0(COMPARE, 16'h0005); wr0(COUNT, 16'h0003);
    rd0(COMPARE, 16'h0005); rd0(COUNT, 16'h0003);
    chk("burst stall0", {15'd0, stall0}, 16'd0);
    idle0(1);
    chk("burst ack count", 16'(ack_cnt0 - base), 16'd6);

    // auto-reload, then one-shot stop
    wr0(COMPARE, 16'h0004); wr0(COUNT, 16'h0); wr0(STATUS, 16'h1); wr0(CTRL, 16'h0003);
    rd0(COUNT, 16'h0000); rd0(COUNT, 16'h0001); rd0(COUNT, 16'h0002); rd0(COUNT, 16'h0003);
    rd0(COUNT, 16'h0004); rd0(COUNT, 16'h0000); rd0(STATUS, 16'h0001);
    wr0(CTRL, 16'h0001);
    idle0(4);
    rd0(COUNT, 16'h0004); rd0(CTRL, 16'h0000);

    // match set wins over STATUS clear; COUNT write wins over tick
    wr0(STATUS, 16'h1); wr0(COMPARE, 16'h0002); wr0(COUNT, 16'h0); wr0(CTRL, 16'h0003);
    idle0(2);
    wr0(STATUS, 16'h1); rd0(STATUS, 16'h0001);
    wr0(COUNT, 16'h0010); rd0(COUNT, 16'h0010);
    wr0(CTRL, 16'h0); wr0(STATUS, 16'h0); rd0(STATUS, 16'h0001);
    wr0(STATUS, 16'h1); rd0(STATUS, 16'h0000);

    // 16-bit wrap without match
    wr0(COMPARE, 16'h0005); wr0(COUNT, 16'hFFFE); wr0(CTRL, 16'h0001);
    rd0(COUNT, 16'hFFFE); rd0(COUNT, 16'hFFFF); rd0(COUNT, 16'h0000); rd0(STATUS, 16'h0000);
    wr0(CTRL, 16'h0); rd0(COUNT, 16'h0003);

    // interrupt path
    wr0(COMPARE, 16'h0001); wr0(COUNT, 16'h0); wr0(CTRL, 16'h0007);
    idle0(2);
    chk("irq before match", {15'd0, irq0}, 16'd0);
    idle0(1);
    chk("irq after match", {15'd0, irq0}, {15'd0, IRQ_ON});
    wr0(CTRL, 16'h0004); wr0(STATUS, 16'h1);
    chk("irq at clear edge", {15'd0, irq0}, {15'd0, IRQ_ON});
    idle0(1);
    chk("irq after clear", {15'd0, irq0}, 16'd0);
    rd0(CTRL, IRQ_ON ? 16'h0004 : 16'h0000);
    wr0(CTRL, 16'h0006); rd0(CTRL, IRQ_ON ? 16'h0006 : 16'h0002); wr0(CTRL, 16'h0);
    idle0(2);

    // wait-state slave
    acc1(1'b0, COMPARE, 16'h0, 16'hFFFF, n);
    chk("dut1 stalls read", 16'(n), 16'd3);
    chk("dut1 ack after accept", {15'd0, ack1}, 16'd1);
    @(posedge clk); #1;
    chk("dut1 ack one cycle", {15'd0, ack1}, 16'd0);
    acc1(1'b1, COMPARE, 16'h00AA, 16'h0, n);
    chk("dut1 stalls write", 16'(n), 16'd3);
    acc1(1'b0, COMPARE, 16'h0, 16'h00AA, n);
    chk("dut1 stalls again", 16'(n), 16'd3);
    cyc1 = 1; stb1 = 1; we1 = 1; adr1 = COMPARE; di1 = 16'h1234;
    @(posedge clk); #1;
    chk("dut1 stall in wait", {15'd0, stall1}, 16'd1);
    cyc1 = 0; stb1 = 0; we1 = 0;
    @(posedge clk); #1;
    chk("dut1 idle stall", {15'd0, stall1}, 16'd0);
    chk("dut1 no ack drop", {15'd0, ack1}, 16'd0);
    @(posedge clk); #1;
    chk("dut1 no ack drop2", {15'd0, ack1}, 16'd0);
    acc1(1'b0, COMPARE, 16'h0, 16'h00AA, n);
    chk("dut1 stalls after drop", 16'(n), 16'd3);
    idle0(2);

    // reset while an ack is pending
    wr0(COMPARE, 16'h0777); rd0(COMPARE, 16'h0777);
    chk("ack before reset", {15'd0, ack0}, 16'd1);
    #1 rst_n = 0;
    #1;
    chk("ack dropped by reset", {15'd0, ack0}, 16'd0);
    chk("dat dropped by reset", dat0, 16'd0);
    q0.delete(); q1.delete();
    #1 rst_n = 1;
    @(posedge clk); #1;
    rd0(COMPARE, 16'hFFFF); rd0(CTRL, 16'h0000); rd0(COUNT, 16'h0000);
    idle0(3);

    chk("dut0 queue drained", 16'(q0.size()), 16'd0);
    chk("dut1 queue drained", 16'(q1.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
